// File: rtl/wave_gen_dds_if.sv
// Sample-stream bundle between the waveform generator (master) and its consumer (slave).
// The slave side also supplies the one-hot waveform request.
interface wave_gen_dds_if;
  logic [3:0] wave_select;
  logic [7:0] data_out;
  logic       data_valid;
  logic       cycle_start;

  modport master (
    input  wave_select,
    output data_out,
    output data_valid,
    output cycle_start
  );

  modport slave (
    output wave_select,
    input  data_out,
    input  data_valid,
    input  cycle_start
  );
endinterface

// File: rtl/wave_gen_dds.sv
// DDS waveform generator: a 32-bit phase accumulator feeds an 8-bit sine/square/
// triangle/sawtooth shaper. The waveform is switched only at a phase wrap.
module wave_gen_dds #(
  parameter logic [31:0] FREQ_CTRL  = 32'd42949,
  parameter logic [7:0]  PHASE_CTRL = 8'd0
) (
  input logic            sys_clk,
  input logic            sys_rst,
  wave_gen_dds_if.master bus
);

  localparam logic [7:0] MIDSCALE = 8'd128;

  // Quarter-wave table: round(127*sin(2*pi*(i+0.5)/256)).
  function automatic logic [6:0] sine_quarter(input logic [5:0] idx);
    logic [6:0] q;
    case (idx)
      6'd0:  q = 7'd2;    6'd1:  q = 7'd5;    6'd2:  q = 7'd8;    6'd3:  q = 7'd11;
      6'd4:  q = 7'd14;   6'd5:  q = 7'd17;   6'd6:  q = 7'd20;   6'd7:  q = 7'd23;
      6'd8:  q = 7'd26;   6'd9:  q = 7'd29;   6'd10: q = 7'd32;   6'd11: q = 7'd35;
      6'd12: q = 7'd38;   6'd13: q = 7'd41;   6'd14: q = 7'd44;   6'd15: q = 7'd47;
      6'd16: q = 7'd50;   6'd17: q = 7'd53;   6'd18: q = 7'd56;   6'd19: q = 7'd58;
      6'd20: q = 7'd61;   6'd21: q = 7'd64;   6'd22: q = 7'd67;   6'd23: q = 7'd69;
      6'd24: q = 7'd72;   6'd25: q = 7'd74;   6'd26: q = 7'd77;   6'd27: q = 7'd79;
      6'd28: q = 7'd82;   6'd29: q = 7'd84;   6'd30: q = 7'd86;   6'd31: q = 7'd89;
      6'd32: q = 7'd91;   6'd33: q = 7'd93;   6'd34: q = 7'd95;   6'd35: q = 7'd97;
      6'd36: q = 7'd99;   6'd37: q = 7'd101;  6'd38: q = 7'd103;  6'd39: q = 7'd105;
      6'd40: q = 7'd106;  6'd41: q = 7'd108;  6'd42: q = 7'd110;  6'd43: q = 7'd111;
      6'd44: q = 7'd113;  6'd45: q = 7'd114;  6'd46: q = 7'd115;  6'd47: q = 7'd117;
      6'd48: q = 7'd118;  6'd49: q = 7'd119;  6'd50: q = 7'd120;  6'd51: q = 7'd121;
      6'd52: q = 7'd122;  6'd53: q = 7'd123;  6'd54: q = 7'd124;  6'd55: q = 7'd124;
      6'd56: q = 7'd125;  6'd57: q = 7'd125;  6'd58: q = 7'd126;  6'd59: q = 7'd126;
      6'd60: q = 7'd127;  6'd61: q = 7'd127;  6'd62: q = 7'd127;  6'd63: q = 7'd127;
      default: q = 7'd127;
    endcase
    return q;
  endfunction

  function automatic logic is_onehot(input logic [3:0] s);
    return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [7:0] shape(input logic [7:0] p, input logic [3:0] sel);
    logic [5:0] idx;
    logic [7:0] q;
    logic [7:0] r;
    idx = p[6] ? ~p[5:0] : p[5:0];
    q   = {1'b0, sine_quarter(idx)};
    case (sel)
      4'b0001: r = p[7] ? (8'd127 - q) : (8'd128 + q);
      4'b0010: r = p[7] ? 8'd0 : 8'd255;
      4'b0100: r = p[7] ? (8'd255 - {p[6:0], 1'b0}) : {p[6:0], 1'b0};
      4'b1000: r = p;
      default: r = MIDSCALE;
    endcase
    return r;
  endfunction

  logic [32:0] acc_sum;
  logic        wrap;

  logic [31:0] phase_acc_p1;
  logic        wrap_p1;
  logic [3:0]  active_sel_p1;
  logic        vld_p1;

  logic [7:0]  addr_p2;
  logic [3:0]  sel_p2;
  logic        wrap_p2;

  logic [7:0]  data_p3;
  logic        cs_p3;
  logic        vld_p3;

  assign acc_sum = {1'b0, phase_acc_p1} + {1'b0, FREQ_CTRL};
  assign wrap    = acc_sum[32];

  // Stage 1: phase accumulation and wrap-gated select capture; an invalid
  // active select is refreshed every clock so start-up needs no wrap.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      phase_acc_p1  <= 32'd0;
      wrap_p1       <= 1'b0;
      active_sel_p1 <= 4'b0000;
      vld_p1        <= 1'b0;
    end else begin
      phase_acc_p1 <= acc_sum[31:0];
      wrap_p1      <= wrap;
      vld_p1       <= 1'b1;
      if (wrap || !is_onehot(active_sel_p1))
        active_sel_p1 <= bus.wave_select;
    end
  end

  // Stage 2: table address; the wrap flag travels with the address whose
  // phase it produced, so cycle_start lands on the period's first sample.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      addr_p2 <= 8'd0;
      sel_p2  <= 4'b0000;
      wrap_p2 <= 1'b0;
    end else begin
      addr_p2 <= phase_acc_p1[31:24] + PHASE_CTRL;
      sel_p2  <= active_sel_p1;
      wrap_p2 <= wrap_p1;
    end
  end

  // Stage 3: waveform shaping and output registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      data_p3 <= MIDSCALE;
      cs_p3   <= 1'b0;
      vld_p3  <= 1'b0;
    end else begin
      data_p3 <= shape(addr_p2, sel_p2);
      cs_p3   <= wrap_p2;
      vld_p3  <= vld_p1;
    end
  end

  assign bus.data_out    = data_p3;
  assign bus.cycle_start = cs_p3;
  assign bus.data_valid  = vld_p3;

endmodule

// File: tb/tb_wave_gen_dds.sv
// Directed bench for wave_gen_dds: reset, sawtooth ramp with deferred switch,
// waveform checkpoint table, phase offset, frozen phase, async mid-period reset.
module tb_wave_gen_dds;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  wave_gen_dds_if m_if ();
  wave_gen_dds_if p_if ();
  wave_gen_dds_if z_if ();

  wave_gen_dds #(.FREQ_CTRL(32'h0100_0000), .PHASE_CTRL(8'd0)) dut (
    .sys_clk(clk), .sys_rst(rst), .bus(m_if));
  wave_gen_dds #(.FREQ_CTRL(32'h0100_0000), .PHASE_CTRL(8'd64)) dut_ph (
    .sys_clk(clk), .sys_rst(rst), .bus(p_if));
  wave_gen_dds #(.FREQ_CTRL(32'd0), .PHASE_CTRL(8'd0)) dut_frz (
    .sys_clk(clk), .sys_rst(rst), .bus(z_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    int         p;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [17];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_cs(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (m_if.cycle_start === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL wait_cycle_start: got no pulse expected pulse within 600 clocks");
  endtask

  // Releases reset at the current falling edge and checks the sawtooth ramp;
  // with do_switch the request toggles mid-period and lands on the wrap clock.
  task automatic run_ramp(input int n, input bit do_switch);
    int         p;
    logic [7:0] e;
    m_if.wave_select = 4'b1000;
    rst = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tick();
      p = (k - 2) & 255;
      if (k <= 2)                  e = 8'd128;
      else if (do_switch && k >= 258) e = (p < 128) ? 8'd255 : 8'd0;
      else                         e = p[7:0];
      check($sformatf("ramp_data k=%0d", k), m_if.data_out, e);
      check($sformatf("ramp_valid k=%0d", k), m_if.data_valid, (k >= 2));
      check($sformatf("ramp_cs k=%0d", k), m_if.cycle_start, (k >= 3 && p == 0));
      if (do_switch) begin
        if (k == 102) m_if.wave_select = 4'b0001;
        if (k == 150) m_if.wave_select = 4'b0100;
        if (k == 255) m_if.wave_select = 4'b0010;
      end
    end
  endtask

  initial begin
    bit ok;
    int cs_count;
    int bad;

    vecs[0]  = '{4'b0001, 0,   8'd130};
    vecs[1]  = '{4'b0001, 32,  8'd219};
    vecs[2]  = '{4'b0001, 64,  8'd255};
    vecs[3]  = '{4'b0001, 128, 8'd125};
    vecs[4]  = '{4'b0001, 192, 8'd0};
    vecs[5]  = '{4'b0100, 0,   8'd0};
    vecs[6]  = '{4'b0100, 127, 8'd254};
    vecs[7]  = '{4'b0100, 128, 8'd255};
    vecs[8]  = '{4'b0100, 200, 8'd111};
    vecs[9]  = '{4'b0010, 0,   8'd255};
    vecs[10] = '{4'b0010, 127, 8'd255};
    vecs[11] = '{4'b0010, 128, 8'd0};
    vecs[12] = '{4'b0010, 255, 8'd0};
    vecs[13] = '{4'b1000, 37,  8'd37};
    vecs[14] = '{4'b1000, 250, 8'd250};
    vecs[15] = '{4'b0000, 10,  8'd128};
    vecs[16] = '{4'b0110, 10,  8'd128};

    rst = 1'b1;
    m_if.wave_select = 4'b1000;
    p_if.wave_select = 4'b1000;
    z_if.wave_select = 4'b0001;

    // Reset held for 10 clocks
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("rst_data i=%0d", i), m_if.data_out, 8'd128);
      check($sformatf("rst_valid i=%0d", i), m_if.data_valid, 1'b0);
      check($sformatf("rst_cs i=%0d", i), m_if.cycle_start, 1'b0);
    end

    // Power-up ramp, several requests in one period, the last on the wrap clock
    run_ramp(514, 1'b1);

    // Phase offset 64: the sample carrying cycle_start is 64
    ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      tick();
      if (p_if.cycle_start === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL phase_cs_wait: got no pulse expected pulse within 600 clocks");
    end else begin
      check("phase_first_sample", p_if.data_out, 8'd64);
      tick();
      check("phase_second_sample", p_if.data_out, 8'd65);
      check("phase_cs_one_clock", p_if.cycle_start, 1'b0);
    end

    // Zero increment: phase frozen at 0, sine output constant, no pulses
    cs_count = 0;
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (z_if.cycle_start !== 1'b0) cs_count++;
      if (z_if.data_out !== 8'd130) bad++;
    end
    check("frozen_cs_pulses", cs_count, 0);
    check("frozen_data_changes", bad, 0);
    check("frozen_valid", z_if.data_valid, 1'b1);

    // Waveform checkpoint table
    for (int v = 0; v < 17; v++) begin
      m_if.wave_select = vecs[v].sel;
      wait_cs(ok);
      if (ok) wait_cs(ok);
      if (ok) begin
        repeat (vecs[v].p) tick();
        check($sformatf("vec%0d sel=%b p=%0d", v, vecs[v].sel, vecs[v].p),
              m_if.data_out, vecs[v].exp);
      end
    end

    // Asynchronous reset between edges at sample 77, then an identical restart
    rst = 1'b1;
    repeat (3) tick();
    m_if.wave_select = 4'b1000;
    rst = 1'b0;
    repeat (79) tick();
    check("pre_reset_sample", m_if.data_out, 8'd77);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_data", m_if.data_out, 8'd128);
    check("async_rst_valid", m_if.data_valid, 1'b0);
    check("async_rst_cs", m_if.cycle_start, 1'b0);
    repeat (4) tick();
    run_ramp(300, 1'b0);

    // Invalid requests after reset: midscale, then a valid one is taken at once
    rst = 1'b1;
    repeat (2) tick();
    m_if.wave_select = 4'b0110;
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("invalid_data k=%0d", k), m_if.data_out, 8'd128);
      if (k == 6) m_if.wave_select = 4'b0000;
    end
    m_if.wave_select = 4'b1000;
    tick();
    check("immediate_sel_e13", m_if.data_out, 8'd128);
    tick();
    check("immediate_sel_e14", m_if.data_out, 8'd128);
    tick();
    check("immediate_sel_e15", m_if.data_out, 8'd13);
    check("immediate_sel_valid", m_if.data_valid, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
